// File: rtl/boot_copier_if.sv
// Boot copier bus bundle: boot ROM read port plus RAM valid/ready write port.
interface boot_copier_if #(
    parameter int unsigned ROM_ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_WIDTH = 16
);
    logic [ROM_ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0]     rom_data;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_wdata;
    logic                      ram_we;
    logic                      ram_ready;

    // Copier side drives addresses and write data.
    modport master (
        output rom_addr, ram_addr, ram_wdata, ram_we,
        input  rom_data, ram_ready
    );

    // Memory side returns ROM data and write acceptance.
    modport slave (
        input  rom_addr, ram_addr, ram_wdata, ram_we,
        output rom_data, ram_ready
    );
endinterface

// File: rtl/boot_copier.sv
// Boot copier: after a start pulse, copies COPY_LEN bytes from boot ROM into
// main RAM (one-cycle ROM latency absorbed), then releases the CPU reset.
module boot_copier #(
    parameter int unsigned ROM_ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_WIDTH = 16,
    parameter int unsigned COPY_LEN       = 256,
    parameter int unsigned RAM_BASE       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    boot_copier_if.master         bus,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_rst_n,
    output logic [DATA_WIDTH-1:0] checksum
);
    // One extra index bit lets a full-depth copy reach its last index without wrapping.
    localparam int unsigned IDX_W = ROM_ADDR_WIDTH + 1;
    localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(COPY_LEN - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] BASE     = RAM_ADDR_WIDTH'(RAM_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
    logic                      ram_we_q, ram_we_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      cpu_rst_n_q, cpu_rst_n_d;
    logic [DATA_WIDTH-1:0]     checksum_q, checksum_d;

    // State and registered outputs; reset aborts any copy in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            checksum_q  <= checksum_d;
        end
    end

    // Next-state and next-output logic: READ -> LATCH -> WRITE per byte.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rom_addr_d  = rom_addr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = ram_we_q;
        busy_d      = busy_q;
        done_d      = done_q;
        cpu_rst_n_d = cpu_rst_n_q;
        checksum_d  = checksum_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_READ;
                    idx_d      = '0;
                    rom_addr_d = '0;
                    checksum_d = '0;
                    busy_d     = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                ram_wdata_d = bus.rom_data;
                ram_addr_d  = BASE + RAM_ADDR_WIDTH'(idx_q);
                ram_we_d    = 1'b1;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                if (bus.ram_ready) begin
                    checksum_d = checksum_q + ram_wdata_q;
                    ram_we_d   = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d     = S_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        rom_addr_d = idx_d[ROM_ADDR_WIDTH-1:0];
                        state_d    = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cpu_rst_n     = cpu_rst_n_q;
    assign checksum      = checksum_q;
endmodule

// File: doc/boot_copier.md
Name: boot_copier

Overview:
Boot-time initiator that drives the boot ROM's synchronous read port. After a start pulse it walks ROM addresses 0..COPY_LEN-1 and absorbs the ROM's one-cycle read latency. Each byte is written into main RAM over a valid/ready write port. The block holds the CPU in reset until the copy completes, then releases it. It sits between the boot ROM, the RAM write arbiter and the CPU reset input.

Parameters:
ROM_ADDR_WIDTH, 8, ROM address width; ROM depth is 2^ROM_ADDR_WIDTH bytes
DATA_WIDTH, 8, ROM/RAM data width
RAM_ADDR_WIDTH, 16, RAM address width
COPY_LEN, 256, bytes to copy; legal range 1..2^ROM_ADDR_WIDTH
RAM_BASE, 0, RAM address receiving ROM byte 0

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin copy; sampled only in IDLE
rom_addr  output  ROM_ADDR_WIDTH  registered address to boot ROM
rom_data  input  DATA_WIDTH  ROM data, valid the cycle after rom_addr is presented
ram_addr  output  RAM_ADDR_WIDTH  registered RAM write address
ram_wdata  output  DATA_WIDTH  registered RAM write data
ram_we  output  1  write valid; held with stable addr/data until ram_ready
ram_ready  input  1  RAM accepts the write on a cycle where ram_we && ram_ready
busy  output  1  high in READ, LATCH and WRITE
done  output  1  sticky high in DONE
cpu_rst_n  output  1  CPU reset, low until DONE
checksum  output  DATA_WIDTH  modulo-2^DATA_WIDTH sum of all bytes accepted by RAM

Behaviour:
- Reset (async, immediate): state=IDLE, idx=0, rom_addr=0, ram_addr=0, ram_wdata=0, ram_we=0, busy=0, done=0, cpu_rst_n=0, checksum=0. A reset mid-copy aborts the copy and drops ram_we in the same instant. Nothing resumes; a new start is required.
- States: IDLE, READ, LATCH, WRITE, DONE.
- IDLE:
  - start=1 -> READ; idx=0; rom_addr=0; checksum=0.
  - start=0 -> stay in IDLE.
- READ: rom_addr=idx is stable this cycle, and the ROM captures mem[idx] at the edge. -> LATCH.
- LATCH: rom_data is valid. Register ram_wdata=rom_data, ram_addr=RAM_BASE+idx (truncated to RAM_ADDR_WIDTH, wraps silently), ram_we=1. -> WRITE.
- WRITE: ram_we=1; ram_addr and ram_wdata are held constant while ram_ready=0 (no timeout).
  - On a cycle with ram_ready=1: checksum += ram_wdata (mod 2^DATA_WIDTH) and ram_we clears at that edge.
  - If idx==COPY_LEN-1 -> DONE.
  - Otherwise idx+1, rom_addr=idx+1, -> READ.
- DONE: done=1, cpu_rst_n=1, busy=0, all stay until rst_n. start is ignored.
- start is ignored in every state except IDLE. A start held high across multiple cycles starts only one copy.
- Throughput: 3 cycles per byte with ram_ready tied high. Total copy time is 3*COPY_LEN cycles from the start-accept edge to the DONE entry edge.
- Counter width: idx is ROM_ADDR_WIDTH+1 bits wide, so COPY_LEN=2^ROM_ADDR_WIDTH terminates without wrap. rom_addr is the low ROM_ADDR_WIDTH bits of idx.
- cpu_rst_n is registered, glitch-free, and rises on the DONE entry edge together with done.
- rom_data is ignored outside LATCH.

Test Plan:
- ROM loaded 0x00..0xFF, COPY_LEN=256, ram_ready=1, one start pulse:
  - RAM[0..255]=0x00..0xFF with one write per address.
  - done and cpu_rst_n rise exactly 768 cycles after the start-accept edge.
  - checksum=0x80.
- ram_ready backpressure: ram_ready low 5 cycles on byte 3 of an 8-byte copy (COPY_LEN=8, ROM=0x11,0x22,...):
  - ram_addr=3 and ram_wdata=0x44 stay stable with ram_we high throughout.
  - No duplicate or skipped writes.
  - DONE is reached 5 cycles later than the unstalled case.
- rst_n asserted mid-copy at idx=10 (COPY_LEN=256):
  - All outputs return to reset values asynchronously; ram_we=0 before the next edge.
  - No further writes occur until a new start; a subsequent start recopies from address 0.
- RAM_BASE=0xFFFE, RAM_ADDR_WIDTH=16, COPY_LEN=4 -> writes land at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- start pulsed during WRITE and again in DONE -> no effect; exactly COPY_LEN writes occur and done stays 1.
- COPY_LEN=1, ROM[0]=0xA5 -> a single write of 0xA5 to RAM_BASE; checksum=0xA5; done 3 cycles after start accept.
